// File: rtl/adder_stim_checker_if.sv
// ---------------------------------------------------------------------------
// adder_stim_checker_if
//   Bus between the stimulus/checker and the 16-bit adder top level.
//   The checker takes the place of the board switches and keys.
//
//   Signals
//     SW     operand bus (checker -> adder)
//     LoadB  active-low load-B strobe, idle 1 (checker -> adder)
//     Run    active-low run strobe, idle 1 (checker -> adder)
//     Sum    adder result (adder -> checker)
//     CO     adder carry-out (adder -> checker)
//
//   Modports
//     master  checker side: drives SW/LoadB/Run, observes Sum/CO
//     slave   adder side:   observes SW/LoadB/Run, drives Sum/CO
// ---------------------------------------------------------------------------
interface adder_stim_checker_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] SW;
  logic             LoadB;
  logic             Run;
  logic [WIDTH-1:0] Sum;
  logic             CO;

  modport master (
    output SW,
    output LoadB,
    output Run,
    input  Sum,
    input  CO
  );

  modport slave (
    input  SW,
    input  LoadB,
    input  Run,
    output Sum,
    output CO
  );
endinterface

// File: rtl/adder_stim_checker.sv
// ---------------------------------------------------------------------------
// adder_stim_checker
//   Synthesizable self-test initiator for the 16-bit adder top level.
//   For every vector it loads B (LoadB low), presents A, pulses Run, waits
//   SETTLE_CYCLES clocks and then compares {CO,Sum} against A+B. The first
//   three vectors are directed corner cases, the rest come from a 32-bit
//   LFSR. Error and vector counts are kept for on-board inspection.
//
//   Ports
//     Clk       in   system clock
//     Reset     in   synchronous active-high reset
//     Start     in   begin a pass (sampled only in IDLE or DONE)
//     bus       master modport of adder_stim_checker_if (SW/LoadB/Run/Sum/CO)
//     Busy      out  high from Start acceptance until DONE is entered
//     Done      out  high in DONE, cleared on the next accepted Start
//     Pass      out  valid with Done: 1 iff ErrorCnt == 0
//     ErrorCnt  out  mismatches in this pass, saturating at 16'hFFFF
//     VecCnt    out  vectors checked in this pass
//
//   Configuration macro
//     ADDER_CHK_STOP_ON_FAIL_EN  when defined, the first mismatch ends the
//                                pass at once with the failing operands
//                                left on SW. Undefined: every vector runs.
//
//   All outputs are registered. Their next values are derived from the
//   next FSM state, so each strobe is asserted during exactly the cycle in
//   which the FSM sits in the corresponding state.
// ---------------------------------------------------------------------------
module adder_stim_checker #(
  parameter int          WIDTH         = 16,
  parameter int          SETTLE_CYCLES = 11,
  parameter int          NUM_VECTORS   = 256,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  adder_stim_checker_if.master  bus,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Pass,
  output logic [15:0]           ErrorCnt,
  output logic [15:0]           VecCnt
);

  // A seed of zero would lock the LFSR up, so it is replaced by one.
  localparam logic [31:0] SEED_EFF   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [15:0] NUM_VEC    = 16'(NUM_VECTORS);
  localparam logic [15:0] SETTLE_END = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADB = 3'd1,
    ST_SETA  = 3'd2,
    ST_RUN   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // One step of the 32-bit Fibonacci LFSR, taps 32,22,2,1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    logic fb;
    fb = cur[31] ^ cur[21] ^ cur[1] ^ cur[0];
    return {cur[30:0], fb};
  endfunction

  // B operand for a vector: directed corner cases first, then LFSR low half.
  function automatic logic [WIDTH-1:0] pick_b(input logic [15:0] vec,
                                              input logic [31:0] lfsr);
    logic [WIDTH-1:0] b;
    case (vec)
      16'd0:   b = WIDTH'(16'hFFFE);
      16'd1:   b = WIDTH'(16'h0ECE);
      16'd2:   b = WIDTH'(16'hFFFF);
      default: b = lfsr[WIDTH-1:0];
    endcase
    return b;
  endfunction

  // A operand for a vector: directed corner cases first, then LFSR upper half.
  function automatic logic [WIDTH-1:0] pick_a(input logic [15:0] vec,
                                              input logic [31:0] lfsr);
    logic [WIDTH-1:0] a;
    case (vec)
      16'd0:   a = WIDTH'(16'h0001);
      16'd1:   a = WIDTH'(16'h0385);
      16'd2:   a = WIDTH'(16'hFFFF);
      default: a = lfsr[2*WIDTH-1:WIDTH];
    endcase
    return a;
  endfunction

  // Saturating increment for the error counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    logic [15:0] res;
    if (cnt == 16'hFFFF) begin
      res = cnt;
    end else begin
      res = cnt + 16'd1;
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_r;
  logic [31:0]      lfsr_r;
  logic [15:0]      settle_r;
  logic [15:0]      err_r;
  logic [15:0]      vec_r;
  logic [WIDTH-1:0] sw_r;
  logic             loadb_r;
  logic             run_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  state_t           state_nxt_s;
  logic [31:0]      lfsr_nxt_s;
  logic [15:0]      settle_nxt_s;
  logic [15:0]      err_nxt_s;
  logic [15:0]      vec_nxt_s;
  logic [WIDTH-1:0] sw_nxt_s;
  logic             loadb_nxt_s;
  logic             run_nxt_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             pass_nxt_s;

  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH-1:0] nxt_a_s;
  logic [WIDTH-1:0] nxt_b_s;
  logic [WIDTH:0]   expect_s;
  logic             mismatch_s;
  logic             last_vec_s;

  // Operands of the vector in flight and the comparison against the adder.
  always_comb begin
    op_a_s     = pick_a(vec_r, lfsr_r);
    op_b_s     = pick_b(vec_r, lfsr_r);
    expect_s   = {1'b0, op_a_s} + {1'b0, op_b_s};
    mismatch_s = ({bus.CO, bus.Sum} != expect_s);
    last_vec_s = ((vec_r + 16'd1) == NUM_VEC);
  end

  // Next-state and next counter values.
  always_comb begin
    state_nxt_s  = state_r;
    lfsr_nxt_s   = lfsr_r;
    settle_nxt_s = settle_r;
    err_nxt_s    = err_r;
    vec_nxt_s    = vec_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_nxt_s = ST_LOADB;
          lfsr_nxt_s  = SEED_EFF;
          err_nxt_s   = 16'd0;
          vec_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOADB: begin
        state_nxt_s = ST_SETA;
      end
      ST_SETA: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        state_nxt_s  = ST_WAIT;
        settle_nxt_s = 16'd0;
      end
      ST_WAIT: begin
        if (settle_r >= SETTLE_END) begin
          state_nxt_s = ST_CHECK;
        end else begin
          settle_nxt_s = settle_r + 16'd1;
        end
      end
      ST_CHECK: begin
        // Sum/CO are looked at only here; the LFSR steps once per vector,
        // directed vectors included, so vector n uses the n-th LFSR state.
        if (mismatch_s) begin
          err_nxt_s = sat_inc(err_r);
        end else begin
          err_nxt_s = err_r;
        end
        vec_nxt_s  = vec_r + 16'd1;
        lfsr_nxt_s = lfsr_step(lfsr_r);
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
        if (mismatch_s || last_vec_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOADB;
        end
`else
        if (last_vec_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_LOADB;
        end
`endif
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next output values, keyed on the state being entered.
  always_comb begin
    // Operands of the vector that will be current after this edge.
    nxt_a_s     = pick_a(vec_nxt_s, lfsr_nxt_s);
    nxt_b_s     = pick_b(vec_nxt_s, lfsr_nxt_s);
    sw_nxt_s    = sw_r;
    loadb_nxt_s = 1'b1;
    run_nxt_s   = 1'b1;
    busy_nxt_s  = 1'b1;
    done_nxt_s  = 1'b0;
    pass_nxt_s  = 1'b0;

    case (state_nxt_s)
      ST_IDLE: begin
        sw_nxt_s   = '0;
        busy_nxt_s = 1'b0;
      end
      ST_LOADB: begin
        sw_nxt_s    = nxt_b_s;
        loadb_nxt_s = 1'b0;
      end
      ST_SETA, ST_WAIT, ST_CHECK: begin
        sw_nxt_s = nxt_a_s;
      end
      ST_RUN: begin
        sw_nxt_s  = nxt_a_s;
        run_nxt_s = 1'b0;
      end
      ST_DONE: begin
        // SW keeps the last (or failing) A operand on display.
        sw_nxt_s   = sw_r;
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
        pass_nxt_s = (err_nxt_s == 16'd0);
      end
      default: begin
        sw_nxt_s   = '0;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      lfsr_r   <= SEED_EFF;
      settle_r <= 16'd0;
      err_r    <= 16'd0;
      vec_r    <= 16'd0;
      sw_r     <= '0;
      loadb_r  <= 1'b1;
      run_r    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      lfsr_r   <= lfsr_nxt_s;
      settle_r <= settle_nxt_s;
      err_r    <= err_nxt_s;
      vec_r    <= vec_nxt_s;
      sw_r     <= sw_nxt_s;
      loadb_r  <= loadb_nxt_s;
      run_r    <= run_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      pass_r   <= pass_nxt_s;
    end
  end

  assign bus.SW    = sw_r;
  assign bus.LoadB = loadb_r;
  assign bus.Run   = run_r;
  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Pass      = pass_r;
  assign ErrorCnt  = err_r;
  assign VecCnt    = vec_r;

endmodule
